// File: rtl/robm_pkg.sv
// Shared definitions for the round-robin actuator-vector arbiter.
package robm_pkg;

   localparam int N_REQ = 3;
   localparam int Y_W   = 10;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Convert a one-hot requester vector into its index (0 for anything not one-hot).
   function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b001:  idx = 2'd0;
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Requester index following idx, wrapping modulo N_REQ.
   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         2'd2:    nxt = 2'd0;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/robm_arb_rr_pick.sv
// Combinational round-robin search: first requester at or above ptr, modulo 3.
module rr_pick
   import robm_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   // Priority chain rotated so that the search starts at ptr.
   always_comb begin
      winner = 3'b000;
      case (ptr)
         2'd1: begin
            if (req[1])      winner = 3'b010;
            else if (req[2]) winner = 3'b100;
            else if (req[0]) winner = 3'b001;
            else             winner = 3'b000;
         end
         2'd2: begin
            if (req[2])      winner = 3'b100;
            else if (req[0]) winner = 3'b001;
            else if (req[1]) winner = 3'b010;
            else             winner = 3'b000;
         end
         default: begin
            // ptr 0, and the unused encoding 3 falls back to the reset order
            if (req[0])      winner = 3'b001;
            else if (req[1]) winner = 3'b010;
            else if (req[2]) winner = 3'b100;
            else             winner = 3'b000;
         end
      endcase
   end

   assign valid = |req;

endmodule

// File: rtl/robm_arb.sv
// Three-way round-robin arbiter for a shared 10-bit actuator command vector.
// The owner holds the vector until done, until it drops its request, or until
// TMO_CYC cycles have elapsed (forced release, flagged by a one-cycle tmo pulse).
// TMO_CYC must lie in 2..15 so that TMO_CYC-1 fits the 4-bit hold counter.
module robm_arb
   import robm_pkg::*;
#(
   parameter int TMO_CYC = 15
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [Y_W-1:0]   cmd0,
   input  logic [Y_W-1:0]   cmd1,
   input  logic [Y_W-1:0]   cmd2,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [Y_W-1:0]   act_y,
   output logic             busy,
   output logic             tmo
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

   state_t             state_r;
   logic [N_REQ-1:0]   gnt_r;
   logic               busy_r;
   logic               tmo_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [1:0]         ptr_r;
   logic [1:0]         owner_r;

   logic [N_REQ-1:0]   pick_win_s;
   logic               pick_vld_s;
   logic               owner_req_s;
   logic               expire_s;
   logic               release_s;
   logic               forced_s;

   rr_pick u_rr_pick (
      .req    (req),
      .ptr    (ptr_r),
      .winner (pick_win_s),
      .valid  (pick_vld_s)
   );

   // Owner's own request bit is selected through the registered one-hot grant.
   assign owner_req_s = |(req & gnt_r);
   assign expire_s    = (cnt_r == CNT_LAST);
   assign release_s   = done | ~owner_req_s | expire_s;
   // Timeout only counts when nothing else would have ended ownership this cycle.
   assign forced_s    = expire_s & ~done & owner_req_s;

   // Arbitration state machine with registered grant, busy, tmo and hold counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         gnt_r   <= 3'b000;
         busy_r  <= 1'b0;
         tmo_r   <= 1'b0;
         cnt_r   <= 4'd0;
         ptr_r   <= 2'd0;
         owner_r <= 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               tmo_r <= 1'b0;
               cnt_r <= 4'd0;
               if (pick_vld_s) begin
                  state_r <= ST_OWN;
                  gnt_r   <= pick_win_s;
                  owner_r <= onehot_to_idx(pick_win_s);
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  gnt_r   <= 3'b000;
                  busy_r  <= 1'b0;
               end
            end
            ST_OWN: begin
               if (release_s) begin
                  state_r <= ST_DRAIN;
                  gnt_r   <= 3'b000;
                  busy_r  <= 1'b1;
                  tmo_r   <= forced_s;
                  ptr_r   <= next_ptr(owner_r);
                  cnt_r   <= 4'd0;
               end else begin
                  state_r <= ST_OWN;
                  tmo_r   <= 1'b0;
                  cnt_r   <= cnt_r + 4'd1;
               end
            end
            ST_DRAIN: begin
               state_r <= ST_IDLE;
               gnt_r   <= 3'b000;
               busy_r  <= 1'b0;
               tmo_r   <= 1'b0;
               cnt_r   <= 4'd0;
            end
            default: begin
               state_r <= ST_IDLE;
               gnt_r   <= 3'b000;
               busy_r  <= 1'b0;
               tmo_r   <= 1'b0;
               cnt_r   <= 4'd0;
            end
         endcase
      end
   end

   // Same-cycle pass-through of the owner's command; zero whenever nobody owns.
   always_comb begin
      act_y = {Y_W{1'b0}};
      if (state_r == ST_OWN) begin
         case (owner_r)
            2'd0:    act_y = cmd0;
            2'd1:    act_y = cmd1;
            2'd2:    act_y = cmd2;
            default: act_y = {Y_W{1'b0}};
         endcase
      end else begin
         act_y = {Y_W{1'b0}};
      end
   end

   assign gnt  = gnt_r;
   assign busy = busy_r;
   assign tmo  = tmo_r;

endmodule
